// File: rtl/button_command_arbiter.sv
// Round-robin arbiter serializing latched push-button command pulses into one command stream.
// Latency: req_pulse at t -> pending at t+1 -> cmd_valid at t+2 (when idle); HOLDOFF_CYCLES idle gap after every accept.
// Backpressure: cmd_valid/cmd_id hold until cmd_ready; new pulses keep latching into pending meanwhile.
//
// Ports:
//   clk          system clock
//   async_reset  asynchronous active-low reset
//   req_pulse    one-cycle request pulses, bit i = requester i (already synchronized)
//   cmd_ready    consumer accepts the presented command this cycle
//   cmd_valid    command presented (registered)
//   cmd_id       index of the granted requester (registered)
//   pending      latched, not-yet-issued requests (registered)
//   overrun      one-cycle pulse: request arrived for an already-pending requester
module button_command_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_WIDTH       = 2,
   parameter int HOLDOFF_CYCLES = 16,
   parameter int HOLDOFF_WIDTH  = 5
) (
   input  logic                clk,
   input  logic                async_reset,
   input  logic [NUM_REQ-1:0]  req_pulse,
   input  logic                cmd_ready,
   output logic                cmd_valid,
   output logic [ID_WIDTH-1:0] cmd_id,
   output logic [NUM_REQ-1:0]  pending,
   output logic                overrun
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     r_cmd_valid;
   logic                     w_cmd_valid_nxt;
   logic [ID_WIDTH-1:0]      r_cmd_id;
   logic [ID_WIDTH-1:0]      w_cmd_id_nxt;
   logic [ID_WIDTH-1:0]      r_last_grant;
   logic [ID_WIDTH-1:0]      w_last_grant_nxt;
   logic [HOLDOFF_WIDTH-1:0] r_cnt;
   logic [HOLDOFF_WIDTH-1:0] w_cnt_nxt;
   logic [NUM_REQ-1:0]       r_pending;
   logic [NUM_REQ-1:0]       w_pending_nxt;
   logic                     r_overrun;
   logic                     w_overrun_nxt;

   logic                     w_accept;
   logic [NUM_REQ-1:0]       w_clr;
   logic                     w_sel_found;
   logic [ID_WIDTH-1:0]      w_sel_id;

   assign w_accept = r_cmd_valid & cmd_ready;

   // Pending latch: a new pulse always wins over the accept-clear of the same bit,
   // so a press landing in the accept cycle is re-issued rather than lost.
   always_comb begin
      w_clr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_clr[i] = w_accept && (r_cmd_id == ID_WIDTH'(i));
      end
      w_pending_nxt = req_pulse | (r_pending & ~w_clr);
      w_overrun_nxt = |(req_pulse & r_pending & ~w_clr);
   end

   // Rotating priority: first pending index above last_grant, else wrap to the
   // lowest pending index at or below it.
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_sel_found && r_pending[i] && (ID_WIDTH'(i) > r_last_grant)) begin
            w_sel_found = 1'b1;
            w_sel_id    = ID_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_sel_found && r_pending[i] && (ID_WIDTH'(i) <= r_last_grant)) begin
            w_sel_found = 1'b1;
            w_sel_id    = ID_WIDTH'(i);
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_cmd_valid_nxt  = r_cmd_valid;
      w_cmd_id_nxt     = r_cmd_id;
      w_last_grant_nxt = r_last_grant;
      w_cnt_nxt        = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_found) begin
               w_cmd_valid_nxt = 1'b1;
               w_cmd_id_nxt    = w_sel_id;
               w_state_nxt     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_accept) begin
               w_cmd_valid_nxt  = 1'b0;
               w_last_grant_nxt = r_cmd_id;
               w_cnt_nxt        = HOLDOFF_WIDTH'(HOLDOFF_CYCLES);
               w_state_nxt      = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            // Counter holds HOLDOFF_CYCLES in the first hold-off cycle, so leaving
            // when it reads 1 gives exactly HOLDOFF_CYCLES hold-off cycles.
            if (r_cnt <= HOLDOFF_WIDTH'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - HOLDOFF_WIDTH'(1);
            end
         end
         default: begin
            w_cmd_valid_nxt = 1'b0;
            w_state_nxt     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         r_state      <= ST_IDLE;
         r_cmd_valid  <= 1'b0;
         r_cmd_id     <= '0;
         r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
         r_cnt        <= '0;
         r_pending    <= '0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cmd_valid  <= w_cmd_valid_nxt;
         r_cmd_id     <= w_cmd_id_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_cnt        <= w_cnt_nxt;
         r_pending    <= w_pending_nxt;
         r_overrun    <= w_overrun_nxt;
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd_id    = r_cmd_id;
   assign pending   = r_pending;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_button_command_arbiter.sv
// Testbench for button_command_arbiter: directed vector table, reset corner sequences,
// and randomized traffic compared every cycle against a timestamp-based reference model.
module tb_button_command_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int H   = 16;
   localparam int HW  = 5;

   logic           clk = 1'b0;
   logic           async_reset;
   logic [N-1:0]   req_pulse;
   logic           cmd_ready;
   logic           cmd_valid;
   logic [IDW-1:0] cmd_id;
   logic [N-1:0]   pending;
   logic           overrun;

   always #5 clk = ~clk;

   button_command_arbiter #(
      .NUM_REQ(N), .ID_WIDTH(IDW), .HOLDOFF_CYCLES(H), .HOLDOFF_WIDTH(HW)
   ) dut (
      .clk(clk),
      .async_reset(async_reset),
      .req_pulse(req_pulse),
      .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid),
      .cmd_id(cmd_id),
      .pending(pending),
      .overrun(overrun)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: requests as a bit array, grant chosen by modulo search from
   // the last grant, hold-off expressed as the cycle number at which granting may resume.
   bit m_pend [N];
   int m_valid, m_id, m_last, m_ovr, m_idle_at;

   function automatic int pend_word();
      int w = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) w = w | (1 << i);
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 0; m_id = 0; m_last = N - 1; m_ovr = 0; m_idle_at = 0; cyc = 0;
   endtask

   task automatic model_step(input logic [N-1:0] req, input logic ready);
      bit acc;
      bit nxt [N];
      int ovr;
      acc = (m_valid != 0) && ready;
      ovr = 0;
      for (int i = 0; i < N; i++) begin
         bit cl;
         cl = acc && (m_id == i);
         if (req[i] && m_pend[i] && !cl) ovr = 1;
         nxt[i] = req[i] || (m_pend[i] && !cl);
      end
      if (acc) begin
         m_valid   = 0;
         m_last    = m_id;
         m_idle_at = cyc + H + 1;
      end else if (m_valid == 0 && cyc >= m_idle_at) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (m_pend[j]) begin
               m_valid = 1;
               m_id    = j;
               break;
            end
         end
      end
      m_pend = nxt;
      m_ovr  = ovr;
      cyc++;
   endtask

   task automatic check_model();
      chk("model_valid", int'(cmd_valid), m_valid);
      chk("model_pending", int'(pending), pend_word());
      chk("model_overrun", int'(overrun), m_ovr);
      if (m_valid != 0) chk("model_cmd_id", int'(cmd_id), m_id);
   endtask

   // Called at a falling edge: drive inputs, step through one rising edge, check at next falling edge.
   task automatic cycle(input logic [N-1:0] req, input logic ready);
      req_pulse = req;
      cmd_ready = ready;
      @(posedge clk);
      model_step(req, ready);
      @(negedge clk);
      check_model();
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic         ready;
      int           n;
      logic         ev;
      int           eid;
      logic [N-1:0] epend;
      logic         eovr;
   } vec_t;

   vec_t tbl [$];

   function automatic void add(input logic [N-1:0] r, input logic rd, input int n,
                               input logic ev, input int eid, input logic [N-1:0] ep, input logic eo);
      vec_t v;
      v = '{r, rd, n, ev, eid, ep, eo};
      tbl.push_back(v);
   endfunction

   initial begin
      logic [N-1:0] rq;
      logic         rd;

      async_reset = 1'b0;
      req_pulse   = '0;
      cmd_ready   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_valid", int'(cmd_valid), 0);
      chk("reset_id", int'(cmd_id), 0);
      chk("reset_pending", int'(pending), 0);
      chk("reset_overrun", int'(overrun), 0);
      async_reset = 1'b1;

      // Simultaneous requests: rotate 0,1,2,3 spaced H+2 cycles apart.
      add(4'b1111, 1, 1,  0, 0, 4'b1111, 0);
      add(4'b0000, 1, 1,  1, 0, 4'b1111, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b1110, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b1110, 0);
      add(4'b0000, 1, 1,  1, 1, 4'b1110, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b1100, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b1100, 0);
      add(4'b0000, 1, 1,  1, 2, 4'b1100, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b1000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b1000, 0);
      add(4'b0000, 1, 1,  1, 3, 4'b1000, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b0000, 0);
      // Single request to requester 2.
      add(4'b0100, 1, 1,  0, 0, 4'b0100, 0);
      add(4'b0000, 1, 1,  1, 2, 4'b0100, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b0000, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      // Back-pressure: 10 cycles of ready low while requester 3 arrives.
      add(4'b0001, 0, 1,  0, 0, 4'b0001, 0);
      add(4'b0000, 0, 1,  1, 0, 4'b0001, 0);
      add(4'b1000, 0, 1,  1, 0, 4'b1001, 0);
      add(4'b0000, 0, 9,  1, 0, 4'b1001, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b1000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b1000, 0);
      add(4'b0000, 1, 1,  1, 3, 4'b1000, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b0000, 0);
      // Overrun: second pulse while pending gives one pulse, one issue.
      add(4'b0010, 0, 1,  0, 0, 4'b0010, 0);
      add(4'b0010, 0, 1,  1, 1, 4'b0010, 1);
      add(4'b0000, 0, 1,  1, 1, 4'b0010, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b0000, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      // Pulse coinciding with accept: no overrun, re-issued after hold-off.
      add(4'b0010, 0, 1,  0, 0, 4'b0010, 0);
      add(4'b0000, 0, 1,  1, 1, 4'b0010, 0);
      add(4'b0010, 1, 1,  0, 0, 4'b0010, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b0010, 0);
      add(4'b0000, 1, 1,  1, 1, 4'b0010, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b0000, 0);
      // Wrap-around: last grant 3 with pending 1001 -> 0 then 3.
      add(4'b1000, 1, 1,  0, 0, 4'b1000, 0);
      add(4'b0000, 1, 1,  1, 3, 4'b1000, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      add(4'b1001, 1, 1,  0, 0, 4'b1001, 0);
      add(4'b0000, 1, 15, 0, 0, 4'b1001, 0);
      add(4'b0000, 1, 1,  1, 0, 4'b1001, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b1000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b1000, 0);
      add(4'b0000, 1, 1,  1, 3, 4'b1000, 0);
      add(4'b0000, 1, 1,  0, 0, 4'b0000, 0);
      add(4'b0000, 1, 16, 0, 0, 4'b0000, 0);

      for (int v = 0; v < tbl.size(); v++) begin
         for (int c = 0; c < tbl[v].n; c++) cycle(tbl[v].req, tbl[v].ready);
         chk($sformatf("tbl%0d_valid", v), int'(cmd_valid), int'(tbl[v].ev));
         chk($sformatf("tbl%0d_pending", v), int'(pending), int'(tbl[v].epend));
         chk($sformatf("tbl%0d_overrun", v), int'(overrun), int'(tbl[v].eovr));
         if (tbl[v].ev) chk($sformatf("tbl%0d_cmd_id", v), int'(cmd_id), tbl[v].eid);
      end

      // Reset in the middle of an issued command to requester 2.
      cycle(4'b0100, 1'b0);
      cycle(4'b0000, 1'b0);
      chk("pre_reset_valid", int'(cmd_valid), 1);
      chk("pre_reset_id", int'(cmd_id), 2);
      #2 async_reset = 1'b0;
      #1;
      chk("async_reset_valid", int'(cmd_valid), 0);
      chk("async_reset_id", int'(cmd_id), 0);
      chk("async_reset_pending", int'(pending), 0);
      chk("async_reset_overrun", int'(overrun), 0);
      model_reset();
      @(negedge clk);
      async_reset = 1'b1;
      // With 3 and 0 pending, a fresh last_grant of 3 must pick requester 0.
      cycle(4'b1001, 1'b1);
      cycle(4'b0000, 1'b1);
      chk("post_reset_valid", int'(cmd_valid), 1);
      chk("post_reset_id", int'(cmd_id), 0);

      // Randomized traffic against the reference model.
      for (int it = 0; it < 3000; it++) begin
         for (int i = 0; i < N; i++) rq[i] = ($urandom_range(7) == 0);
         rd = ($urandom_range(9) < 7);
         cycle(rq, rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_command_arbiter.md
# button_command_arbiter

Round-robin arbiter that turns single-cycle command pulses from several edge-detected DE0 push-buttons/switches into a serialized command stream for the associative buffer control path. Each requester's pulse is latched as pending. One command is issued at a time over a valid/ready handshake. A programmable hold-off gap follows every accepted command so that back-to-back buffer operations are spaced.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 2, width of cmd_id; must satisfy 2^ID_WIDTH >= NUM_REQ
- HOLDOFF_CYCLES, 16, idle cycles inserted after each accepted command (1..2^HOLDOFF_WIDTH-1)
- HOLDOFF_WIDTH, 5, hold-off counter width

Ports:
- clk  input  1  system clock
- async_reset  input  1  asynchronous, active-low reset
- req_pulse  input  NUM_REQ  one-cycle request pulses, already synchronized, bit i = requester i
- cmd_ready  input  1  consumer accepts the command this cycle
- cmd_valid  output  1  command presented (registered)
- cmd_id  output  ID_WIDTH  index of the granted requester (registered)
- pending  output  NUM_REQ  latched, not-yet-issued requests (registered)
- overrun  output  1  one-cycle pulse: a request arrived for an already-pending requester

## Operation
- Reset (async_reset low, asynchronous): state IDLE, cmd_valid=0, cmd_id=0, pending=0, overrun=0, hold-off counter=0, last_grant=NUM_REQ-1. Any in-flight command is discarded; no output glitches after release.
- Pending latch: pending[i] sets on req_pulse[i]. It clears on accept (cmd_valid & cmd_ready) with cmd_id==i. If set and clear coincide for the same i, set wins: the bit stays 1 and no overrun is raised.
- overrun is asserted the cycle after req_pulse[i] when pending[i] was already 1 and was not being cleared that cycle. The request is merged and not counted twice.
- FSM states IDLE, ISSUE, HOLDOFF:
  - IDLE: if pending != 0, select the first set bit searching upward from (last_grant+1) mod NUM_REQ, with wrap-around. Register cmd_id, set cmd_valid=1, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: cmd_valid=1. cmd_id holds stable until accept. Requests arriving meanwhile do not change cmd_id. On cmd_ready: clear pending[cmd_id], last_grant<=cmd_id, cmd_valid<=0, load counter with HOLDOFF_CYCLES, go to HOLDOFF.
  - HOLDOFF: decrement the counter each cycle. When it reaches 0, go to IDLE. New pulses are still latched into pending.
- cmd_ready while cmd_valid=0 is ignored.

## Timing
- req_pulse[i] at cycle t: pending[i]=1 at t+1. If in IDLE, cmd_valid=1 at t+2.
- Accept at cycle a: cmd_valid=0 at a+1. HOLDOFF occupies cycles a+1..a+HOLDOFF_CYCLES. IDLE is at a+HOLDOFF_CYCLES+1. The earliest next cmd_valid is at a+HOLDOFF_CYCLES+2.
- With cmd_ready tied high, a command stays valid for exactly 1 cycle. The minimum command period is HOLDOFF_CYCLES+2.
- Fairness: with all requesters continuously pending, grants rotate 0,1,…,NUM_REQ-1,0.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

## Test plan
- Reset mid-ISSUE: with cmd_valid=1 and cmd_id=2, pull async_reset low -> all outputs 0 immediately. After release, the first grant goes to requester 0 when it is pending.
- Single request: req_pulse=4'b0100 at t with cmd_ready=1 -> pending=4'b0100 at t+1. cmd_valid=1 and cmd_id=2 at t+2. pending=0 and cmd_valid=0 at t+3. Next valid is no earlier than t+20 (HOLDOFF_CYCLES=16).
- Simultaneous requests: req_pulse=4'b1111 in one cycle, cmd_ready=1 -> cmd_id sequence 0,1,2,3, each spaced 18 cycles apart. pending steps 1110, 1100, 1000, 0000.
- Back-pressure: cmd_ready=0 for 10 cycles during ISSUE while req_pulse[3] fires -> cmd_valid and cmd_id stay stable. pending[3] sets. Requester 3 is granted after the current command is accepted.
- Overrun and coincidence: pulse requester 1 twice while it is pending -> overrun is one 1-cycle pulse and requester 1 is issued once. Pulse requester 1 in the same cycle it is accepted -> no overrun, pending[1] stays 1, and it is reissued after hold-off.
- Wrap-around: last_grant=3 with pending=4'b1001 -> next cmd_id=0, then 3.
